// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and FSM state type for the round-robin stream mux
package mux_pkg;
  localparam int N_CH = 8;
  localparam int SEL_W = $clog2(N_CH);
  typedef enum logic {IDLE, LOCKED} mux_state_t;
endpackage

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [SEL_W-1:0] start;
  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    start = ptr + SEL_W'(1);
    rot = N_CH'({req, req} >> start);
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
    gnt_idx = start + off;
    gnt_vld = |req;
  end
endmodule

// File: rtl/rr_mux_8to1.sv
// rr_mux_8to1: 8-to-1 valid/ready merge with round-robin arbitration and packet lock
module rr_mux_8to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_last,
  input  logic                  out_ready
);
  mux_state_t       state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d, arb_idx, grant;
  logic             arb_vld, grant_vld, can_load, take;
  logic             out_valid_q, out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;
  rr_arbiter_8 u_arb (
    .req    (in_valid),
    .ptr    (rr_ptr_q),
    .gnt_idx(arb_idx),
    .gnt_vld(arb_vld)
  );
  // While locked, grant equals lock_ch which already equals rr_ptr, so one update rule covers both states
  always_comb begin
    grant = (state_q == LOCKED) ? lock_ch_q : arb_idx;
    grant_vld = (state_q == LOCKED) ? in_valid[lock_ch_q] : arb_vld;
    can_load = ~out_valid_q | out_ready;
    take = grant_vld & can_load;
    in_ready = take ? (N_CH'(1) << grant) : '0;
    rr_ptr_d = take ? grant : rr_ptr_q;
    lock_ch_d = take ? grant : lock_ch_q;
    state_d = take ? (in_last[grant] ? IDLE : LOCKED) : state_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= SEL_W'(N_CH - 1);
      lock_ch_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
      if (can_load) out_valid_q <= take;
      if (take) begin
        out_data_q <= in_data[grant*WIDTH +: WIDTH];
        out_sel_q <= grant;
        out_last_q <= in_last[grant];
      end
    end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
  assign out_last = out_last_q;
endmodule

// File: tb/tb_rr_mux_8to1.sv
// tb_rr_mux_8to1: directed arbitration checks plus per-channel scoreboard under random traffic
module tb_rr_mux_8to1;
  logic        clk, rst, out_ready, out_valid, out_last;
  logic [7:0]  in_valid, in_last, in_ready, out_data;
  logic [63:0] in_data;
  logic [2:0]  out_sel;
  int          checks, failures;
  logic [8:0]  sbq [8][$];
  logic [7:0]  acc, vld, lst, popen;
  logic [4:0]  cnt [8];
  logic        hold, open, drain;
  logic [11:0] held;
  logic [2:0]  open_ch;
  logic [8:0]  e;

  rr_mux_8to1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] d, input logic l);
    in_data[c*8 +: 8] = d;
    in_last[c] = l;
  endtask

  task automatic check_beat(input string tag, input logic [2:0] sel, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
    check({tag, "_sel"}, 32'(out_sel), 32'(sel));
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_last"}, 32'(out_last), 32'(l));
  endtask

  // Monitor: scoreboard push on input handshakes, pop on output handshakes
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < 8; c++) sbq[c].delete();
      hold = 1'b0;
      open = 1'b0;
      acc = '0;
    end else begin
      check("onehot_ready", 32'($onehot0(in_ready)), 32'(1));
      if (hold) check("out_hold", 32'({out_valid, out_last, out_sel, out_data}), 32'({1'b1, held}));
      hold = out_valid & ~out_ready;
      held = {out_last, out_sel, out_data};
      if (out_valid & out_ready) begin
        if (sbq[out_sel].size() == 0)
          check("sb_underflow", 32'(sbq[out_sel].size()), 32'(1));
        else begin
          e = sbq[out_sel].pop_front();
          check("sb_beat", 32'({out_last, out_data}), 32'(e));
        end
        if (open) check("no_interleave", 32'(out_sel), 32'(open_ch));
        open = ~out_last;
        open_ch = out_sel;
      end
      acc = in_valid & in_ready;
      for (int c = 0; c < 8; c++)
        if (acc[c]) sbq[c].push_back({in_last[c], in_data[c*8 +: 8]});
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    out_ready = 1'b1;
    vld = '0;
    lst = '0;
    popen = '0;
    drain = 1'b0;
    for (int c = 0; c < 8; c++) cnt[c] = '0;
    tick;
    tick;
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_sel", 32'(out_sel), 32'(0));
    check("rst_last", 32'(out_last), 32'(0));
    rst = 1'b0;
    // 1: all channels requesting single-beat packets, strict rotation from channel 0
    for (int c = 0; c < 8; c++) set_ch(c, 8'(16 + c), 1'b1);
    in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick;
      check_beat("t1", 3'(k % 8), 8'(16 + k % 8), 1'b1);
    end
    in_valid = '0;
    tick;
    check("t1_drain", 32'(out_valid), 32'(0));
    // 2: three-beat packet on channel 2 locks out channel 5
    set_ch(2, 8'd11, 1'b0);
    set_ch(5, 8'd55, 1'b1);
    in_valid = 8'b0010_0100;
    tick;
    check_beat("t2_b0", 3'd2, 8'd11, 1'b0);
    set_ch(2, 8'd12, 1'b0);
    tick;
    check_beat("t2_b1", 3'd2, 8'd12, 1'b0);
    set_ch(2, 8'd13, 1'b1);
    tick;
    check_beat("t2_b2", 3'd2, 8'd13, 1'b1);
    in_valid = 8'b0010_0000;
    tick;
    check_beat("t2_ch5", 3'd5, 8'd55, 1'b1);
    in_valid = '0;
    tick;
    // 3: output stall holds data and blocks inputs, then resumes without a bubble
    set_ch(6, 8'hA5, 1'b1);
    in_valid = 8'h40;
    tick;
    check_beat("t3_a5", 3'd6, 8'hA5, 1'b1);
    out_ready = 1'b0;
    set_ch(6, 8'hB6, 1'b1);
    set_ch(7, 8'hC7, 1'b1);
    in_valid = 8'hC0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check_beat("t3_stall", 3'd6, 8'hA5, 1'b1);
      check("t3_ready_low", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    #1;
    check("t3_ready_ch7", 32'(in_ready), 32'(8'h80));
    tick;
    check_beat("t3_c7", 3'd7, 8'hC7, 1'b1);
    in_valid = 8'h40;
    tick;
    check_beat("t3_b6", 3'd6, 8'hB6, 1'b1);
    in_valid = '0;
    tick;
    // 4: wrap-around from rr_ptr=7 picks channel 0 before channel 6
    set_ch(7, 8'h77, 1'b1);
    in_valid = 8'h80;
    tick;
    check_beat("t4_ch7", 3'd7, 8'h77, 1'b1);
    set_ch(0, 8'h70, 1'b1);
    set_ch(6, 8'h76, 1'b1);
    in_valid = 8'h41;
    tick;
    check_beat("t4_ch0", 3'd0, 8'h70, 1'b1);
    in_valid = 8'h40;
    tick;
    check_beat("t4_ch6", 3'd6, 8'h76, 1'b1);
    in_valid = '0;
    tick;
    // 5: reset while locked on channel 3 restarts the search at channel 0
    set_ch(3, 8'h33, 1'b0);
    in_valid = 8'h08;
    tick;
    check_beat("t5_ch3", 3'd3, 8'h33, 1'b0);
    set_ch(3, 8'h34, 1'b0);
    set_ch(1, 8'h21, 1'b1);
    in_valid = 8'h0A;
    rst = 1'b1;
    tick;
    check("t5_rst_valid", 32'(out_valid), 32'(0));
    rst = 1'b0;
    tick;
    check_beat("t5_ch1", 3'd1, 8'h21, 1'b1);
    in_valid = '0;
    tick;
    // 6: random traffic, then a drain phase that closes every open packet
    for (int n = 0; n < 10300; n++) begin
      drain = (n >= 10000);
      for (int c = 0; c < 8; c++) begin
        if (acc[c] && vld[c]) begin
          vld[c] = 1'b0;
          popen[c] = ~lst[c];
        end
        if (!vld[c] && (drain ? popen[c] : ($urandom_range(1, 0) == 1))) begin
          vld[c] = 1'b1;
          in_data[c*8 +: 8] = {c[2:0], cnt[c]};
          cnt[c] = cnt[c] + 5'd1;
          lst[c] = drain ? 1'b1 : ($urandom_range(2, 0) == 0);
        end
      end
      in_valid = vld;
      in_last = lst;
      out_ready = drain ? 1'b1 : ($urandom_range(3, 0) != 0);
      tick;
    end
    check("t6_all_sent", 32'(vld & ~acc), 32'(0));
    in_valid = '0;
    out_ready = 1'b1;
    tick;
    tick;
    check("t6_out_idle", 32'(out_valid), 32'(0));
    for (int c = 0; c < 8; c++) check("t6_sb_empty", 32'(sbq[c].size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
